// File: rtl/scmp_pkg.sv
// Shared definitions for the serial symbol comparator: FSM states, symbol
// width and the one-hot verdict encoding {eq, gt, lt}.
package scmp_pkg;

    localparam int SYM_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] VERDICT_NONE = 3'b000;
    localparam logic [2:0] VERDICT_EQ   = 3'b100;
    localparam logic [2:0] VERDICT_GT   = 3'b010;
    localparam logic [2:0] VERDICT_LT   = 3'b001;

    // Map the decision flags onto the one-hot verdict word.
    function automatic logic [2:0] verdict_encode(input logic decided, input logic pending_gt);
        logic [2:0] v;
        if (!decided) begin
            v = VERDICT_EQ;
        end else if (pending_gt) begin
            v = VERDICT_GT;
        end else begin
            v = VERDICT_LT;
        end
        return v;
    endfunction

endpackage

// File: rtl/sym_cmp2.sv
// Combinational comparator for one pair of 2-bit symbols (unsigned).
module sym_cmp2
    import scmp_pkg::*;
(
    input  logic [SYM_W-1:0] i_x,
    input  logic [SYM_W-1:0] i_y,
    output logic             o_s_eq,
    output logic             o_s_gt
);

    // Per-symbol equality and unsigned magnitude.
    always_comb begin
        o_s_eq = (i_x == i_y);
        o_s_gt = (i_x > i_y);
    end

endmodule

// File: rtl/serial_symbol_compare.sv
// MSB-first serial comparator of two 2-bit symbol streams; registers an
// eq/gt/lt verdict, a match count and an overflow flag per compare.
module serial_symbol_compare
    import scmp_pkg::*;
#(
    parameter int MAX_SYMBOLS = 16,
    parameter int CW          = 5
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [SYM_W-1:0] x,
    input  logic [SYM_W-1:0] y,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    match_cnt,
    output logic             err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_start_take;
    logic            w_accept;
    logic            w_last_slot;
    logic            w_finish;
    logic            w_overflow;
    logic            w_s_eq;
    logic            w_s_gt;
    logic            w_decided_nxt;
    logic            w_pending_nxt;
    logic [CW-1:0]   w_match_nxt;

    logic [CW-1:0]   r_beat_cnt;
    logic [CW-1:0]   r_match_cnt;
    logic            r_decided;
    logic            r_pending_gt;
    logic            r_err;
    logic            r_busy;
    logic            r_done;
    logic [2:0]      r_verdict;

    sym_cmp2 u_sym_cmp2 (
        .i_x    (x),
        .i_y    (y),
        .o_s_eq (w_s_eq),
        .o_s_gt (w_s_gt)
    );

    // Beat qualification and decision-after-this-beat values.
    always_comb begin
        w_accept      = in_valid & (r_state == ST_RUN);
        w_last_slot   = (r_beat_cnt == CW'(MAX_SYMBOLS - 1));
        w_finish      = w_accept & (in_last | w_last_slot);
        w_overflow    = w_accept & w_last_slot & ~in_last;
        // The first differing symbol fixes the outcome; later beats cannot change it.
        w_decided_nxt = r_decided | ~w_s_eq;
        w_pending_nxt = r_decided ? r_pending_gt : w_s_gt;
        if (w_s_eq && (r_match_cnt != CW'(MAX_SYMBOLS))) begin
            w_match_nxt = r_match_cnt + CW'(1);
        end else begin
            w_match_nxt = r_match_cnt;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_RUN;
                    w_start_take = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt  = ST_RUN;
                    w_start_take = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_start_take = 1'b0;
            end
        endcase
    end

    // State register plus registered status decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Compare datapath: cleared on an accepted start, updated on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt   <= '0;
            r_match_cnt  <= '0;
            r_decided    <= 1'b0;
            r_pending_gt <= 1'b0;
            r_err        <= 1'b0;
            r_verdict    <= VERDICT_NONE;
        end else if (w_start_take) begin
            r_beat_cnt   <= '0;
            r_match_cnt  <= '0;
            r_decided    <= 1'b0;
            r_pending_gt <= 1'b0;
            r_err        <= 1'b0;
            r_verdict    <= VERDICT_NONE;
        end else if (w_accept) begin
            r_beat_cnt   <= r_beat_cnt + CW'(1);
            r_match_cnt  <= w_match_nxt;
            r_decided    <= w_decided_nxt;
            r_pending_gt <= w_pending_nxt;
            if (w_finish) begin
                r_verdict <= verdict_encode(w_decided_nxt, w_pending_nxt);
                r_err     <= w_overflow;
            end else begin
                r_verdict <= r_verdict;
                r_err     <= r_err;
            end
        end else begin
            r_beat_cnt   <= r_beat_cnt;
            r_match_cnt  <= r_match_cnt;
            r_decided    <= r_decided;
            r_pending_gt <= r_pending_gt;
            r_err        <= r_err;
            r_verdict    <= r_verdict;
        end
    end

    assign in_ready  = (r_state == ST_RUN);
    assign busy      = r_busy;
    assign done      = r_done;
    assign eq        = r_verdict[2];
    assign gt        = r_verdict[1];
    assign lt        = r_verdict[0];
    assign match_cnt = r_match_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_serial_symbol_compare.sv
// Scoreboard bench for serial_symbol_compare: a reference model pushes the
// expected verdict as beats are driven; each test pops it at the done cycle.
module tb_serial_symbol_compare;

    typedef struct {
        logic       eq;
        logic       gt;
        logic       lt;
        logic       err;
        logic [4:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_last;
    logic [1:0] x;
    logic [1:0] y;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       eq;
    logic       gt;
    logic       lt;
    logic [4:0] match_cnt;
    logic       err;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t e;

    // Reference model of the compare in progress.
    logic m_decided;
    logic m_gt;
    int   m_match;
    int   m_beats;

    serial_symbol_compare #(.MAX_SYMBOLS(16), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .x         (x),
        .y         (y),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .match_cnt (match_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_decided = 1'b0;
        m_gt      = 1'b0;
        m_match   = 0;
        m_beats   = 0;
    endtask

    task automatic begin_compare();
        start = 1'b1;
        model_clear();
        cycle();
        start = 1'b0;
    endtask

    // Drive one accepted beat and push the expected verdict when it ends the compare.
    task automatic send_beat(input logic [1:0] bx, input logic [1:0] by, input logic blast);
        exp_t ex;
        in_valid = 1'b1;
        in_last  = blast;
        x        = bx;
        y        = by;
        if (bx == by) begin
            if (m_match < 16) m_match++;
        end else if (!m_decided) begin
            m_decided = 1'b1;
            m_gt      = (bx > by);
        end
        m_beats++;
        if (blast || m_beats == 16) begin
            ex.eq  = !m_decided;
            ex.gt  = m_decided && m_gt;
            ex.lt  = m_decided && !m_gt;
            ex.err = (m_beats == 16) && !blast;
            ex.cnt = 5'(m_match);
            sb.push_back(ex);
        end
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, busy, done, eq, gt, lt, match_cnt, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b, required 0", {in_ready, busy, done, eq, gt, lt, match_cnt, err});
        end
        cycle();
        rst = 1'b0;
        cycle();
        begin_compare();
        send_beat(2'd1, 2'd1, 1'b0);
        send_beat(2'd2, 2'd2, 1'b0);
        send_beat(2'd3, 2'd3, 1'b0);
        n_checks++;
        if (match_cnt !== 5'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prerun: got cnt=%0d busy=%b, required cnt=3 busy=1", match_cnt, busy);
        end
        rst = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, busy, done, eq, gt, lt, match_cnt, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: got %b, required 0", {in_ready, busy, done, eq, gt, lt, match_cnt, err});
        end
        cycle();
        rst = 1'b0;
        cycle();
        begin_compare();
        send_beat(2'd1, 2'd1, 1'b0);
        send_beat(2'd2, 2'd2, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL reset_after: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        n_checks++;
        if (eq !== 1'b1 || match_cnt !== 5'd2) begin
            n_fail++;
            $display("FAIL reset_after_const: got eq=%b cnt=%0d, required eq=1 cnt=2", eq, match_cnt);
        end
        cycle();
    endtask

    task automatic test_greater();
        begin_compare();
        send_beat(2'd2, 2'd2, 1'b0);
        send_beat(2'd3, 2'd1, 1'b0);
        send_beat(2'd0, 2'd3, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL greater: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        n_checks++;
        if (gt !== 1'b1 || lt !== 1'b0 || eq !== 1'b0 || match_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL greater_const: got gt=%b lt=%b eq=%b cnt=%0d, required 1 0 0 1", gt, lt, eq, match_cnt);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || gt !== 1'b1 || match_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL greater_hold: got done=%b busy=%b gt=%b cnt=%0d, required 0 0 1 1", done, busy, gt, match_cnt);
        end
        cycle();
    endtask

    task automatic test_less();
        begin_compare();
        send_beat(2'd0, 2'd1, 1'b0);
        send_beat(2'd3, 2'd3, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL less: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        cycle();
    endtask

    task automatic test_overflow();
        begin_compare();
        for (int i = 0; i < 16; i++) begin
            send_beat(2'd1, 2'd1, 1'b0);
        end
        in_valid = 1'b1;
        x        = 2'd2;
        y        = 2'd2;
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL overflow: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_ready: got in_ready=%b, required 0", in_ready);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || eq !== 1'b1 || match_cnt !== 5'd16 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_held: got err=%b eq=%b cnt=%0d busy=%b, required 1 1 16 0", err, eq, match_cnt, busy);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        begin_compare();
        send_beat(2'd3, 2'd0, 1'b1);
        start = 1'b1;
        model_clear();
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        cycle();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || {eq, gt, lt} !== 3'b000 || match_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_cleared: got ready=%b done=%b v=%b%b%b cnt=%0d, required 1 0 000 0",
                     in_ready, done, eq, gt, lt, match_cnt);
        end
        send_beat(2'd1, 2'd1, 1'b0);
        start = 1'b1;
        send_beat(2'd1, 2'd2, 1'b0);
        start = 1'b0;
        send_beat(2'd0, 2'd0, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || lt !== 1'b1 || match_cnt !== 5'd2) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b lt=%b cnt=%0d, required 0 1 2", busy, lt, match_cnt);
        end
        cycle();
    endtask

    task automatic test_idle_collision();
        start    = 1'b1;
        in_valid = 1'b1;
        x        = 2'd3;
        y        = 2'd3;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready: got in_ready=%b, required 0", in_ready);
        end
        cycle();
        start    = 1'b0;
        in_valid = 1'b0;
        send_beat(2'd2, 2'd2, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || {eq, gt, lt, err, match_cnt} !== {e.eq, e.gt, e.lt, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL collision: got done=%b v=%b%b%b err=%b cnt=%0d, required done=1 v=%b%b%b err=%b cnt=%0d",
                     done, eq, gt, lt, err, match_cnt, e.eq, e.gt, e.lt, e.err, e.cnt);
        end
        cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x        = 2'd0;
        y        = 2'd0;
        model_clear();
        #1;
        test_reset();
        test_greater();
        test_less();
        test_overflow();
        test_back_to_back();
        test_idle_collision();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_symbol_compare.md
# serial_symbol_compare

Sequential magnitude and equality comparator for two 2-bit-symbol streams. It sits directly upstream of the team's combinational 2-bit pair matcher in the compare datapath. It accepts one symbol pair per cycle, MSB-symbol first, and produces a registered verdict (eq/gt/lt), a count of matching symbol positions and a one-cycle done pulse. Downstream logic consumes the held verdict.

## Interface
- `MAX_SYMBOLS`, default 16: maximum symbols per compare; also the saturation limit of `match_cnt`.
- `CW`, default 5: width of `match_cnt`; must satisfy 2^CW > MAX_SYMBOLS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new compare. Honoured in IDLE or DONE, ignored in RUN.
- `in_valid` in 1: a symbol pair is present.
- `in_last` in 1: the current beat is the final symbol. Qualified by `in_valid`.
- `x` in 2: symbol of operand X.
- `y` in 2: symbol of operand Y.
- `in_ready` out 1: high only in RUN; a beat is accepted when `in_valid & in_ready`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a verdict is registered.
- `eq`, `gt`, `lt` out 1 each: verdict, one-hot after the first done; held until the next accepted start.
- `match_cnt` out CW: number of accepted beats with x==y, saturating at MAX_SYMBOLS.
- `err` out 1: set when MAX_SYMBOLS beats are accepted without `in_last`; held like the verdict.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE→RUN on `start`. On entry, clear `eq`/`gt`/`lt`/`err`/`match_cnt`, the internal `decided` flag and the beat counter.
- In RUN, each accepted beat does the following:
  - If x==y, increment `match_cnt` (saturating).
  - If `decided`=0 and x≠y, set `decided` and latch `pending_gt` = (x>y) as unsigned 2-bit. Later beats never change the decision, because MSB-first ordering is fixed.
  - Increment the beat counter.
- RUN→DONE on an accepted beat with `in_last`, or on the accepted beat that brings the counter to MAX_SYMBOLS. In the overflow case, also set `err`.
- On the RUN→DONE transition, register the verdict: `eq`=!decided, `gt`=decided&pending_gt, `lt`=decided&!pending_gt.
- In DONE, `done`=1 for exactly one cycle.
  - Next state is RUN if `start`=1, otherwise IDLE.
  - Verdict, `match_cnt` and `err` are held in IDLE.
- `start` during RUN is ignored and has no side effect.
- `in_valid` outside RUN is ignored, because `in_ready`=0.
- `start` and `in_valid` in the same IDLE cycle: only the start takes effect; the beat is not accepted.
- `rst` at any time returns to IDLE asynchronously and clears every output. Reset value of all outputs is 0.

## Timing
- The first beat can be accepted one cycle after `start` is sampled.
- Throughput is one beat per cycle, with no bubbles.
- The verdict, `match_cnt`, `err` and `done` are all visible in the cycle after the last accepted beat (latency 1).
- Back-to-back compares: `start` asserted during the DONE cycle makes the next cycle RUN. The minimum gap between the last beat of one compare and the first beat of the next is 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs except `in_ready`, which is derived from state only.

## Structure
- Shared package `scmp_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the symbol width constant `SYM_W`=2;
  - the verdict encoding constants.
- One sub-module, `sym_cmp2`: a combinational per-symbol comparator producing `s_eq` and `s_gt` from x and y. Instantiate it once.
- FSM, counters and verdict registers live in the top level.

## Test plan
- **Reset:** hold `rst` mid-RUN after 3 beats → all outputs 0 immediately, `in_ready`=0. After release, start plus beats (1,1),(2,2) last → eq=1, match_cnt=2.
- **Greater-than:** start, then beats (2,2),(3,1),(0,3) last → done pulse 1 cycle after the last beat, gt=1, lt=0, eq=0, match_cnt=1.
- **Less-than:** beats (0,1),(3,3) last → lt=1, match_cnt=1.
- **Overflow:** 16 beats of (1,1) with `in_last`=0 → done after the 16th beat, err=1, eq=1, match_cnt=16. A 17th `in_valid` is not accepted.
- **Back-to-back and ignored start:** assert `start` in the DONE cycle → the next compare's first beat is accepted 1 cycle later and the previous verdict is cleared. `start` pulsed during RUN → no effect on counts or verdict.
- **IDLE collision:** `start` and `in_valid` together in IDLE → that beat is dropped and `match_cnt` excludes it.
